vc_switch_bank: RTL and testbench

Multi-channel, clocked voltage-controlled switch controller: the digital successor to the single SPICE-style VC switch device, generalised to CHANNELS independent switches with threshold and hysteresis. Each channel compares a sampled signed control value against an on-level (VT+VH) and an off-level (VT−VH). A channel changes state only after HOLD consecutive qualifying samples. Per-channel force overrides and one-cycle toggle pulses are provided. The block sits between the sampled control-voltage datapath and the switch-conductance selection logic (ron/roff).

---
 rtl/vc_switch_bank.sv | 133 +++++++++++++
 tb/tb_vc_switch_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_switch_bank.sv
// Bank of independent hysteretic voltage-controlled switches with debounce (HOLD) and force override.
// One-cycle latency from sample to sw_on/toggled; no backpressure, one sample per cycle.
module vc_switch_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12,
  parameter int VT       = 0,
  parameter int VH       = 1,
  parameter int HOLD     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_v,
  input  logic [CHANNELS-1:0]       force_en,
  input  logic [CHANNELS-1:0]       force_val,
  output logic [CHANNELS-1:0]       sw_on,
  output logic [CHANNELS-1:0]       toggled,
  output logic                      out_valid
);

  typedef enum logic [1:0] {S_OFF, S_PEND_ON, S_ON, S_PEND_OFF} state_t;

  // Two guard bits keep VT+/-VH exact even at the extremes of the sample range.
  localparam int LW   = WIDTH + 2;
  localparam int HI_I = VT + VH;
  localparam int LO_I = VT - VH;
  localparam logic signed [LW-1:0] HI = LW'(HI_I);
  localparam logic signed [LW-1:0] LO = LW'(LO_I);
  localparam logic [3:0] HOLD_C = 4'(HOLD);

  logic [CHANNELS-1:0] sw_d;
  logic [CHANNELS-1:0] toggled_q;
  logic                out_valid_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic signed [LW-1:0] v;
    logic                 above;
    logic                 below;
    state_t               st_q, st_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           cnt_inc;

    assign v       = LW'($signed(in_v[i*WIDTH +: WIDTH]));
    assign above   = v > HI;
    assign below   = v < LO;
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (force_en[i]) begin
        st_d  = force_val[i] ? S_ON : S_OFF;
        cnt_d = 4'd0;
      end else if (in_valid) begin
        case (st_q)
          S_OFF: begin
            if (above) begin
              if (HOLD_C == 4'd1) begin
                st_d = S_ON;
              end else begin
                st_d  = S_PEND_ON;
                cnt_d = 4'd1;
              end
            end
          end
          S_PEND_ON: begin
            if (!above) begin
              st_d  = S_OFF;
              cnt_d = 4'd0;
            end else if (cnt_inc == HOLD_C) begin
              st_d  = S_ON;
              cnt_d = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          S_ON: begin
            if (below) begin
              if (HOLD_C == 4'd1) begin
                st_d = S_OFF;
              end else begin
                st_d  = S_PEND_OFF;
                cnt_d = 4'd1;
              end
            end
          end
          S_PEND_OFF: begin
            if (!below) begin
              st_d  = S_ON;
              cnt_d = 4'd0;
            end else if (cnt_inc == HOLD_C) begin
              st_d  = S_OFF;
              cnt_d = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            st_d  = S_OFF;
            cnt_d = 4'd0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= S_OFF;
        cnt_q <= 4'd0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign sw_on[i] = (st_q == S_ON) || (st_q == S_PEND_OFF);
    assign sw_d[i]  = (st_d == S_ON) || (st_d == S_PEND_OFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggled_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      toggled_q   <= sw_d ^ sw_on;
      out_valid_q <= in_valid;
    end
  end

  assign toggled   = toggled_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vc_switch_bank.sv
// Directed bench for vc_switch_bank: three parameterisations share stimulus and are checked
// every cycle against a run-length model, plus hand-computed spot checks.
module tb_vc_switch_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  force_en;
  logic [3:0]  force_val;
  int          samp [4];

  logic [47:0] in_v_a;
  logic [23:0] in_v_b;
  logic [11:0] in_v_c;
  logic [3:0]  sw_a, tog_a;
  logic [1:0]  sw_b, tog_b;
  logic [0:0]  sw_c, tog_c;
  logic        ov_a, ov_b, ov_c;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign in_v_a[g*12 +: 12] = samp[g][11:0];
  end
  assign in_v_b = {samp[1][11:0], samp[0][11:0]};
  assign in_v_c = samp[0][11:0];

  vc_switch_bank #(.CHANNELS(4), .WIDTH(12), .VT(100), .VH(10), .HOLD(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_v(in_v_a),
    .force_en(force_en), .force_val(force_val),
    .sw_on(sw_a), .toggled(tog_a), .out_valid(ov_a));

  vc_switch_bank #(.CHANNELS(2), .WIDTH(12), .VT(2047), .VH(10), .HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_v(in_v_b),
    .force_en(force_en[1:0]), .force_val(force_val[1:0]),
    .sw_on(sw_b), .toggled(tog_b), .out_valid(ov_b));

  vc_switch_bank #(.CHANNELS(1), .WIDTH(12), .VT(-2047), .VH(5), .HOLD(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_v(in_v_c),
    .force_en(force_en[0:0]), .force_val(force_val[0:0]),
    .sw_on(sw_c), .toggled(tog_c), .out_valid(ov_c));

  logic [3:0] sw_all  [3];
  logic [3:0] tog_all [3];
  logic       ov_all  [3];
  assign sw_all[0]  = sw_a;
  assign sw_all[1]  = {2'b00, sw_b};
  assign sw_all[2]  = {3'b000, sw_c};
  assign tog_all[0] = tog_a;
  assign tog_all[1] = {2'b00, tog_b};
  assign tog_all[2] = {3'b000, tog_c};
  assign ov_all[0]  = ov_a;
  assign ov_all[1]  = ov_b;
  assign ov_all[2]  = ov_c;

  int hi_m   [3] = '{110, 2057, -2042};
  int lo_m   [3] = '{90, 2037, -2052};
  int hold_m [3] = '{3, 1, 1};
  int nch_m  [3] = '{4, 2, 1};

  // Model: a switch flips after HOLD consecutive valid samples beyond the level opposite its state.
  bit m_on  [3][4];
  int m_run [3][4];
  bit m_tog [3][4];
  bit m_ov;

  function automatic bit qual(input int i, input int c);
    return m_on[i][c] ? (samp[c] < lo_m[i]) : (samp[c] > hi_m[i]);
  endfunction

  function automatic int run_after(input int i, input int c);
    if (force_en[c]) return 0;
    if (!in_valid) return m_run[i][c];
    if (!qual(i, c)) return 0;
    return m_run[i][c] + 1;
  endfunction

  function automatic bit on_next(input int i, input int c);
    if (force_en[c]) return force_val[c];
    return (run_after(i, c) == hold_m[i]) ? !m_on[i][c] : m_on[i][c];
  endfunction

  function automatic int run_next(input int i, input int c);
    return (run_after(i, c) == hold_m[i]) ? 0 : run_after(i, c);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 4; c++) begin
          m_on[i][c]  <= 1'b0;
          m_run[i][c] <= 0;
          m_tog[i][c] <= 1'b0;
        end
      end
      m_ov <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 4; c++) begin
          m_on[i][c]  <= on_next(i, c);
          m_run[i][c] <= run_next(i, c);
          m_tog[i][c] <= on_next(i, c) != m_on[i][c];
        end
      end
      m_ov <= in_valid;
    end
  end

  function automatic logic [3:0] m_vec(input int i, input bit want_tog);
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      if (c < nch_m[i]) r[c] = want_tog ? m_tog[i][c] : m_on[i][c];
    end
    return r;
  endfunction

  int n_pass = 0;
  int n_tot  = 0;
  bit done   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!done) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_sw_on[%0d]", i), int'(sw_all[i]), int'(m_vec(i, 1'b0)));
        chk($sformatf("model_toggled[%0d]", i), int'(tog_all[i]), int'(m_vec(i, 1'b1)));
        chk($sformatf("model_out_valid[%0d]", i), int'(ov_all[i]), int'(m_ov));
      end
    end
  end

  task automatic step(input bit v);
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    force_en  = '0;
    force_val = '0;
    for (int c = 0; c < 4; c++) samp[c] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_sw_on", int'(sw_a), 0);
    chk("reset_out_valid", int'(ov_a), 0);
    rst_n = 1'b1;

    // Hysteresis on ch0
    samp[0] = 105; step(1'b1);
    samp[0] = 111; step(1'b1); step(1'b1);
    chk("hyst_pending_off", int'(sw_a[0]), 0);
    step(1'b1);
    chk("hyst_on", int'(sw_a[0]), 1);
    chk("hyst_on_pulse", int'(tog_a[0]), 1);
    chk("hold1_latency_c", int'(sw_c[0]), 1);
    samp[0] = 95; step(1'b1);
    chk("hyst_pulse_single", int'(tog_a[0]), 0);
    step(1'b1); step(1'b1);
    chk("hyst_band_stays_on", int'(sw_a[0]), 1);
    samp[0] = 89; step(1'b1); step(1'b1);
    chk("hyst_pend_off_still_on", int'(sw_a[0]), 1);
    step(1'b1);
    chk("hyst_off", int'(sw_a[0]), 0);
    chk("hyst_off_pulse", int'(tog_a[0]), 1);
    samp[0] = 0;

    // Run break on ch1: equality with hi does not qualify
    samp[1] = 120; step(1'b1); step(1'b1);
    samp[1] = 110; step(1'b1);
    samp[1] = 120; step(1'b1); step(1'b1);
    chk("runbreak_not_yet", int'(sw_a[1]), 0);
    step(1'b1);
    chk("runbreak_on", int'(sw_a[1]), 1);

    // Valid gaps on ch2
    samp[2] = 120; step(1'b1);
    step(1'b0);
    chk("gap_out_valid_low", int'(ov_a), 0);
    for (int k = 0; k < 4; k++) step(1'b0);
    step(1'b1);
    chk("gap_out_valid_high", int'(ov_a), 1);
    chk("gap_second_valid_off", int'(sw_a[2]), 0);
    step(1'b1);
    chk("gap_third_valid_on", int'(sw_a[2]), 1);

    // Force on ch3
    samp[3] = -2048; force_en = 4'b1000; force_val = 4'b1000; step(1'b1);
    chk("force_on", int'(sw_a[3]), 1);
    chk("force_on_pulse", int'(tog_a[3]), 1);
    force_en = '0; samp[3] = 91;
    for (int k = 0; k < 3; k++) step(1'b1);
    chk("force_release_stays_on", int'(sw_a[3]), 1);
    force_en = 4'b1000; step(1'b1);
    chk("force_same_no_pulse", int'(tog_a[3]), 0);
    force_val = 4'b0000; samp[3] = 200; step(1'b1);
    chk("force_beats_sample", int'(sw_a[3]), 0);
    force_en = '0; samp[3] = 0; step(1'b0);

    // Asynchronous reset in the middle of a pending run on ch0
    samp[0] = 120; step(1'b1); step(1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_sw_on", int'(sw_a), 0);
    chk("async_reset_toggled", int'(tog_a), 0);
    chk("async_reset_out_valid", int'(ov_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1); step(1'b1);
    chk("reset_discards_run", int'(sw_a[0]), 0);
    step(1'b1);
    chk("post_reset_fresh_run", int'(sw_a[0]), 1);

    // Extremes: levels beyond the sample range stay exact
    force_en = 4'b0001; force_val = 4'b0000; step(1'b0);
    force_en = '0; samp[0] = 2047; samp[1] = 0;
    step(1'b1);
    chk("extreme_c_hold1_on", int'(sw_c[0]), 1);
    chk("extreme_c_hold1_pulse", int'(tog_c[0]), 1);
    step(1'b1); step(1'b1);
    chk("extreme_b_max_never_on", int'(sw_b[0]), 0);
    samp[0] = -2048; step(1'b1); step(1'b1);
    chk("extreme_c_min_no_wrap", int'(sw_c[0]), 1);
    step(1'b0);

    @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
